// File: rtl/ucode_sequencer.sv
// rtl/ucode_sequencer.sv - microcode fetch/sequencing stage with uPC, ROM fetch and op handshake
// Optional step watchdog enabled by defining UCODE_WATCHDOG_EN.
module ucode_sequencer #(
   parameter int UPC_W   = 8,
   parameter int UWORD_W = 32
`ifdef UCODE_WATCHDOG_EN
   ,
   parameter int MAX_STEPS = 1024
`endif
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               start,
   input  logic [UPC_W-1:0]   entry_addr,
   input  logic               alu_zero,
   input  logic               stall,
   output logic               rom_en,
   output logic [UPC_W-1:0]   rom_addr,
   input  logic [UWORD_W-1:0] rom_data,
   output logic               op_valid,
   output logic [3:0]         op_port_a_reg,
   output logic [3:0]         op_port_b_reg,
   output logic               op_port_a_we,
   output logic [3:0]         op_alu_op,
   output logic               op_alu_use_imm,
   output logic               op_alu_shift_right,
   output logic               op_jump_on_zero,
   output logic               op_ex_jump,
   output logic               op_in_alu,
   output logic               op_in_rf,
   output logic               op_in_dmem,
   output logic               op_in_imm,
   output logic               op_out_rf_write,
   output logic               op_out_dm_write,
   output logic [7:0]         op_immediate,
   output logic               op_signal_done,
   output logic               busy,
   output logic               done,
   output logic               wdt_error
);

   typedef enum logic [1:0] {S_IDLE, S_FETCH, S_EXEC} state_t;

   state_t             state_q, state_d;
   logic [UPC_W-1:0]   upc_q, upc_d;
   logic [UWORD_W-1:0] op_q, op_d;
   logic               op_valid_q, op_valid_d;
   logic               done_q, done_d;
   logic [7:0]         imm;
   logic [UPC_W-1:0]   upc_next;

`ifdef UCODE_WATCHDOG_EN
   localparam int SW = $clog2(MAX_STEPS + 1);
   localparam logic [SW-1:0] STEP_LAST = SW'(MAX_STEPS - 1);
   logic [SW-1:0] step_q, step_d;
   logic          wdt_q, wdt_d;
`endif

   // ExJump wins over JumpOnZero; both jump to the same Immediate target.
   always_comb begin
      imm = op_q[8:1];
      if (op_q[15] || (op_q[16] && alu_zero)) begin
         upc_next = imm[UPC_W-1:0];
      end else begin
         upc_next = upc_q + UPC_W'(1);
      end
   end

   always_comb begin
      state_d    = state_q;
      upc_d      = upc_q;
      op_d       = op_q;
      op_valid_d = op_valid_q;
      done_d     = 1'b0;
      rom_en     = 1'b0;
      rom_addr   = '0;
`ifdef UCODE_WATCHDOG_EN
      step_d     = step_q;
      wdt_d      = wdt_q;
`endif
      case (state_q)
         S_IDLE: begin
            if (start) begin
               rom_en   = 1'b1;
               rom_addr = entry_addr;
               upc_d    = entry_addr;
               state_d  = S_FETCH;
`ifdef UCODE_WATCHDOG_EN
               step_d   = '0;
               wdt_d    = 1'b0;
`endif
            end
         end
         S_FETCH: begin
            op_d       = rom_data;
            op_valid_d = 1'b1;
            state_d    = S_EXEC;
         end
         S_EXEC: begin
            if (!stall) begin
               op_d       = '0;
               op_valid_d = 1'b0;
`ifdef UCODE_WATCHDOG_EN
               step_d     = step_q + SW'(1);
`endif
               if (op_q[0]) begin
                  done_d  = 1'b1;
                  state_d = S_IDLE;
`ifdef UCODE_WATCHDOG_EN
               end else if (step_q == STEP_LAST) begin
                  wdt_d   = 1'b1;
                  state_d = S_IDLE;
`endif
               end else begin
                  rom_en   = 1'b1;
                  rom_addr = upc_next;
                  upc_d    = upc_next;
                  state_d  = S_FETCH;
               end
            end
         end
         default: state_d = S_IDLE;
      endcase
      if (!rst_n) begin
         rom_en   = 1'b0;
         rom_addr = '0;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q    <= S_IDLE;
         upc_q      <= '0;
         op_q       <= '0;
         op_valid_q <= 1'b0;
         done_q     <= 1'b0;
`ifdef UCODE_WATCHDOG_EN
         step_q     <= '0;
         wdt_q      <= 1'b0;
`endif
      end else begin
         state_q    <= state_d;
         upc_q      <= upc_d;
         op_q       <= op_d;
         op_valid_q <= op_valid_d;
         done_q     <= done_d;
`ifdef UCODE_WATCHDOG_EN
         step_q     <= step_d;
         wdt_q      <= wdt_d;
`endif
      end
   end

`ifdef UCODE_WATCHDOG_EN
   assign wdt_error = wdt_q;
`else
   assign wdt_error = 1'b0;
`endif

   // op_q is cleared whenever op_valid drops, so fields read 0 outside EXEC.
   assign op_valid           = op_valid_q;
   assign op_port_a_reg      = op_q[31:28];
   assign op_port_b_reg      = op_q[27:24];
   assign op_port_a_we       = op_q[23];
   assign op_alu_op          = op_q[22:19];
   assign op_alu_use_imm     = op_q[18];
   assign op_alu_shift_right = op_q[17];
   assign op_jump_on_zero    = op_q[16];
   assign op_ex_jump         = op_q[15];
   assign op_in_alu          = op_q[14];
   assign op_in_rf           = op_q[13];
   assign op_in_dmem         = op_q[12];
   assign op_in_imm          = op_q[11];
   assign op_out_rf_write    = op_q[10];
   assign op_out_dm_write    = op_q[9];
   assign op_immediate       = op_q[8:1];
   assign op_signal_done     = op_q[0];
   assign busy               = (state_q != S_IDLE);
   assign done               = done_q;

endmodule

// File: tb/tb_ucode_sequencer.sv
// tb/tb_ucode_sequencer.sv - self-checking bench for ucode_sequencer
module tb_ucode_sequencer;

   logic       clk = 1'b0;
   logic       rst_n, start, alu_zero, stall;
   logic [7:0] entry_addr;
   logic       rom_en;
   logic [7:0] rom_addr;
   logic [31:0] rom_data;
   logic       op_valid, op_port_a_we, op_alu_use_imm, op_alu_shift_right;
   logic       op_jump_on_zero, op_ex_jump, op_in_alu, op_in_rf, op_in_dmem, op_in_imm;
   logic       op_out_rf_write, op_out_dm_write, op_signal_done, busy, done, wdt_error;
   logic [3:0] op_port_a_reg, op_port_b_reg, op_alu_op;
   logic [7:0] op_immediate;

   int vectors = 0;
   int miscompares = 0;

   logic [31:0] rom [256];

   ucode_sequencer dut (
      .clk(clk), .rst_n(rst_n), .start(start), .entry_addr(entry_addr),
      .alu_zero(alu_zero), .stall(stall), .rom_en(rom_en), .rom_addr(rom_addr),
      .rom_data(rom_data), .op_valid(op_valid),
      .op_port_a_reg(op_port_a_reg), .op_port_b_reg(op_port_b_reg),
      .op_port_a_we(op_port_a_we), .op_alu_op(op_alu_op),
      .op_alu_use_imm(op_alu_use_imm), .op_alu_shift_right(op_alu_shift_right),
      .op_jump_on_zero(op_jump_on_zero), .op_ex_jump(op_ex_jump),
      .op_in_alu(op_in_alu), .op_in_rf(op_in_rf), .op_in_dmem(op_in_dmem),
      .op_in_imm(op_in_imm), .op_out_rf_write(op_out_rf_write),
      .op_out_dm_write(op_out_dm_write), .op_immediate(op_immediate),
      .op_signal_done(op_signal_done), .busy(busy), .done(done), .wdt_error(wdt_error)
   );

   always #5 clk = ~clk;

   always @(posedge clk) if (rom_en) rom_data <= rom[rom_addr];

   wire [31:0] op_word = {op_port_a_reg, op_port_b_reg, op_port_a_we, op_alu_op,
                          op_alu_use_imm, op_alu_shift_right, op_jump_on_zero, op_ex_jump,
                          op_in_alu, op_in_rf, op_in_dmem, op_in_imm,
                          op_out_rf_write, op_out_dm_write, op_immediate, op_signal_done};

   task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, got, exp, $time);
      end
   endtask

   // Model: a fetch requested in cycle t presents its op in t+2 and holds it until
   // a non-stalled cycle; the routine's uPC trace follows the jump rules on ROM words.
   int          m_due = -1;
   logic        m_done = 1'b0;
   logic [7:0]  m_upc = 8'h00;
   logic [31:0] m_word;
   logic        m_en;
   logic [7:0]  m_nxt;

   always @(negedge clk) begin
      if (!rst_n) begin
         m_due  = -1;
         m_done = 1'b0;
      end else begin
         if (m_due > 0) m_due--;
         chk("busy", 32'(busy), 32'(m_due >= 0));
         chk("done", 32'(done), 32'(m_done));
         m_done = 1'b0;
         chk("wdt_error", 32'(wdt_error), 32'h0);
         chk("op_valid", 32'(op_valid), 32'(m_due == 0));
         m_word = (m_due == 0) ? rom[m_upc] : 32'h0;
         chk("op_fields", op_word, m_word);
         m_en  = 1'b0;
         m_nxt = 8'h00;
         if (m_due < 0 && start) begin
            m_en  = 1'b1;
            m_nxt = entry_addr;
            m_upc = entry_addr;
            m_due = 2;
         end else if (m_due == 0 && !stall) begin
            if (m_word[0]) begin
               m_done = 1'b1;
               m_due  = -1;
            end else begin
               if (m_word[15] || (m_word[16] && alu_zero)) m_nxt = m_word[8:1];
               else m_nxt = m_upc + 8'h01;
               m_en  = 1'b1;
               m_upc = m_nxt;
               m_due = 2;
            end
         end
         chk("rom_en", 32'(rom_en), 32'(m_en));
         if (m_en) chk("rom_addr", 32'(rom_addr), 32'(m_nxt));
      end
   end

   task automatic start_at(input logic [7:0] a);
      start = 1'b1;
      entry_addr = a;
      @(posedge clk); #1;
      start = 1'b0;
   endtask

   task automatic wait_done(input string nm);
      int n;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (done !== 1'b1 && n < 40);
      chk(nm, 32'(done), 32'h1);
      chk({nm, "_busy"}, 32'(busy), 32'h0);
      @(posedge clk); #1;
   endtask

   initial begin
      #200000;
      $display("FAIL timeout: bench did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      for (int i = 0; i < 256; i++) rom[i] = 32'h0;
      rom[8'h10] = 32'h12800000;
      rom[8'h11] = 32'h00000001;
      rom[8'h05] = 32'h00008080;
      rom[8'h40] = 32'h30004001;
      rom[8'h30] = 32'h00010040;
      rom[8'h20] = 32'h00000001;
      rom[8'h31] = 32'h00000001;
      rom[8'h70] = 32'h5A3C0E00;
      rom[8'h71] = 32'h00000001;
      rom[8'hFF] = 32'h00000C00;
      rom[8'h00] = 32'h00000001;

      rst_n = 1'b0; start = 1'b0; alu_zero = 1'b0; stall = 1'b0; entry_addr = 8'h00;
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
      @(negedge clk);
      chk("rst_fields", op_word, 32'h0);
      chk("rst_op_valid", 32'(op_valid), 32'h0);
      chk("rst_busy", 32'(busy), 32'h0);
      chk("rst_rom_en", 32'(rom_en), 32'h0);
      chk("rst_rom_addr", 32'(rom_addr), 32'h0);
      @(posedge clk); #1;

      // Basic two-op routine at 0x10.
      start_at(8'h10);
      @(negedge clk); @(negedge clk);
      chk("t1_a_reg", 32'(op_port_a_reg), 32'h1);
      chk("t1_b_reg", 32'(op_port_b_reg), 32'h2);
      chk("t1_a_we", 32'(op_port_a_we), 32'h1);
      chk("t1_rom_addr", 32'(rom_addr), 32'h11);
      @(negedge clk); @(negedge clk);
      chk("t1_sig_done", 32'(op_signal_done), 32'h1);
      wait_done("t1_done");
      chk("t1_done_once", 32'(done), 32'h0);

      // ExJump at 0x05 to 0x40.
      start_at(8'h05);
      @(negedge clk); @(negedge clk);
      chk("exj_rom_en", 32'(rom_en), 32'h1);
      chk("exj_rom_addr", 32'(rom_addr), 32'h40);
      wait_done("exj_done");

      // JumpOnZero taken and not taken.
      alu_zero = 1'b1;
      start_at(8'h30);
      @(negedge clk); @(negedge clk);
      chk("jz1_rom_addr", 32'(rom_addr), 32'h20);
      wait_done("jz1_done");
      alu_zero = 1'b0;
      start_at(8'h30);
      @(negedge clk); @(negedge clk);
      chk("jz0_rom_addr", 32'(rom_addr), 32'h31);
      wait_done("jz0_done");

      // Stall held for three EXEC cycles.
      start_at(8'h70);
      stall = 1'b1;
      @(negedge clk);
      repeat (3) begin
         @(negedge clk);
         chk("stall_rom_en", 32'(rom_en), 32'h0);
         chk("stall_valid", 32'(op_valid), 32'h1);
         chk("stall_word", op_word, 32'h5A3C0E00);
      end
      @(posedge clk); #1;
      stall = 1'b0;
      @(negedge clk);
      chk("unstall_rom_en", 32'(rom_en), 32'h1);
      chk("unstall_rom_addr", 32'(rom_addr), 32'h71);
      wait_done("stall_done");

      // uPC wrap from 0xFF, with start pulsed while busy.
      start_at(8'hFF);
      start = 1'b1;
      entry_addr = 8'h10;
      @(negedge clk);
      chk("busy_start_rom_en", 32'(rom_en), 32'h0);
      @(posedge clk); #1;
      start = 1'b0;
      @(negedge clk);
      chk("wrap_rom_addr", 32'(rom_addr), 32'h00);
      wait_done("wrap_done");

      // Reset during EXEC aborts without a done pulse.
      start_at(8'h70);
      @(posedge clk); #1;
      rst_n = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(negedge clk);
      chk("abort_fields", op_word, 32'h0);
      chk("abort_valid", 32'(op_valid), 32'h0);
      chk("abort_busy", 32'(busy), 32'h0);
      chk("abort_rom_en", 32'(rom_en), 32'h0);
      chk("abort_done0", 32'(done), 32'h0);
      @(negedge clk);
      chk("abort_done1", 32'(done), 32'h0);
      repeat (3) @(posedge clk);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/ucode_sequencer.md
Name: ucode_sequencer

Overview:
- Microcode fetch/sequencing stage directly upstream of the micro-op bundle consumed by the register file, ALU, transfer and control logic.
- Owns the micro-PC (uPC) and reads 32-bit words from a synchronous-read microcode ROM.
- Unpacks each word into the micro-op fields, presents one op at a time with a valid/stall handshake, and resolves ExJump, JumpOnZero and SignalDone.

Parameters:
- UPC_W, 8, uPC / ROM address width. Jump target is Immediate[UPC_W-1:0]; UPC_W must be 8 or less.
- UWORD_W, 32, ROM word width. Fixed at 32 by the field layout.
- MAX_STEPS, 1024, watchdog op limit. Used only with the optional feature.

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous active-low reset
- start  in  1  begin a routine; sampled only in IDLE
- entry_addr  in  UPC_W  first uPC of the routine
- alu_zero  in  1  registered ALU zero flag from the datapath
- stall  in  1  downstream cannot accept; hold the current op
- rom_en  out  1  ROM read strobe
- rom_addr  out  UPC_W  ROM address (combinational)
- rom_data  in  UWORD_W  ROM data, valid the cycle after rom_en
- op_valid  out  1  op fields are live
- op_port_a_reg, op_port_b_reg  out  4 each
- op_port_a_we  out  1
- op_alu_op  out  4
- op_alu_use_imm, op_alu_shift_right  out  1 each
- op_jump_on_zero, op_ex_jump  out  1 each
- op_in_alu, op_in_rf, op_in_dmem, op_in_imm  out  1 each
- op_out_rf_write, op_out_dm_write  out  1 each
- op_immediate  out  8
- op_signal_done  out  1
- busy  out  1  state is not IDLE
- done  out  1  one-cycle pulse when a routine ends
- wdt_error  out  1  watchdog fault (optional feature only)

Behaviour:
- Reset and clock:
  - One clock. Reset is synchronous, active-low, on rst_n.
  - Reset drives all outputs to 0, uPC to 0 and state to IDLE.
  - Reset mid-routine aborts immediately and produces no done pulse.
- ROM word layout, MSB first:
  - [31:28] PortAReg, [27:24] PortBReg, [23] PortAWriteEnable, [22:19] ALUOp
  - [18] ALUUsePortBImm, [17] ALUShiftDirection, [16] JumpOnZero, [15] ExJump
  - [14] InUseALU, [13] InUseRF, [12] InUseDMEM, [11] InUseImm
  - [10] OutRFWrite, [9] OutDMWrite, [8:1] Immediate, [0] SignalDone
- States:
  - IDLE: rom_en = start, rom_addr = entry_addr. On start, uPC <= entry_addr and go to FETCH.
  - FETCH: rom_data is valid. Latch it into the op register, set op_valid, go to EXEC.
  - EXEC: op held on outputs with op_valid = 1.
    - If stall = 1: outputs and uPC hold, rom_en = 0.
    - If stall = 0 and SignalDone = 1: clear the op register and op_valid, pulse done, go to IDLE.
    - Otherwise compute next uPC:
      - ExJump set: Immediate.
      - Else JumpOnZero and alu_zero: Immediate.
      - Else uPC + 1, modulo 2^UPC_W (255 wraps to 0).
    - Drive rom_en = 1 and rom_addr = next uPC, update uPC, clear op_valid and fields to 0, go to FETCH.
- Sampling rules:
  - alu_zero is sampled only in a non-stalled EXEC cycle.
  - ExJump takes priority over JumpOnZero.
- Timing:
  - start in cycle 0 gives op_valid in cycle 2.
  - Steady throughput is one op per 2 cycles.
  - done asserts in the cycle after the final EXEC.
- When op_valid = 0, all op fields read 0, so no stray write enables reach the datapath.
- start while busy is ignored.

Optional Feature:
- Macro: UCODE_WATCHDOG_EN.
- Defined:
  - A step counter clears on start and increments on each non-stalled EXEC.
  - If it reaches MAX_STEPS without SignalDone, the block returns to IDLE, clears the op outputs, gives no done pulse, and sets wdt_error sticky high until the next start or reset.
- Undefined: no counter is built and wdt_error is tied to 0.

Test Plan:
- Reset then start at entry 0x10, ROM[0x10] = 0x12800000 and ROM[0x11] = 0x00000001:
  - cycle 2: op_port_a_reg = 1, op_port_b_reg = 2, op_port_a_we = 1;
  - next op has op_signal_done = 1;
  - done pulses once, then busy = 0.
- ExJump word with Immediate 0x40 at 0x05 -> next rom_addr = 0x40.
- JumpOnZero with Immediate 0x20:
  - alu_zero = 1 -> rom_addr = 0x20;
  - alu_zero = 0 -> rom_addr = uPC + 1.
- stall held 3 cycles in EXEC -> fields and op_valid are stable for all 3 cycles, rom_en = 0; the op advances on the cycle stall drops.
- uPC 0xFF, non-jump op -> rom_addr = 0x00. start pulsed while busy has no effect.
- rst_n low during EXEC -> next cycle all outputs are 0 and no done pulse. With UCODE_WATCHDOG_EN and MAX_STEPS = 4, a self-loop routine sets wdt_error after 4 ops.
